excess3_bcd_packer: RTL and testbench

EXCESS3_BCD_PACKER -- requirements
Module: excess3_bcd_packer

---
 rtl/excess3_bcd_packer.sv | 130 +++++++++++++
 tb/tb_excess3_bcd_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/excess3_bcd_packer.sv
// Packs Excess-3 digits into a BCD word with ready/valid on both sides.
// Optional binary conversion of the packed word is enabled by EXCESS3_BIN_EN.
module excess3_bcd_packer #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_xs3,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic [3:0]        out_cnt,
`ifdef EXCESS3_BIN_EN
  output logic [4*NDIG-1:0] out_bin,
`endif
  output logic              out_err
);

  localparam int W = 4 * NDIG;

`ifdef EXCESS3_BIN_EN
  typedef enum logic [1:0] {ACC = 2'd0, CONV = 2'd1, OUT = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ACC = 2'd0, OUT = 2'd2} state_t;
`endif

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           legal;
  logic [3:0]     digit;
`ifdef EXCESS3_BIN_EN
  logic [W-1:0]   bin_q, bin_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     conv_digit;
`endif

  // Illegal codes decode as digit 0 and poison the whole word.
  assign legal = (in_xs3 >= 4'd3) && (in_xs3 <= 4'd12);
  assign digit = legal ? (in_xs3 - 4'd3) : 4'd0;

`ifdef EXCESS3_BIN_EN
  assign conv_digit = 4'(acc_q >> {idx_q, 2'b00});
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef EXCESS3_BIN_EN
    bin_d   = bin_q;
    idx_d   = idx_q;
`endif
    case (state_q)
      ACC: begin
        if (in_valid) begin
          acc_d = (acc_q << 4) | W'(digit);
          cnt_d = cnt_q + 4'd1;
          err_d = err_q | ~legal;
          if ((cnt_q + 4'd1 == 4'(NDIG)) || in_last) begin
`ifdef EXCESS3_BIN_EN
            // Conversion walks from the most significant used digit down.
            state_d = CONV;
            bin_d   = '0;
            idx_d   = 3'(cnt_q);
`else
            state_d = OUT;
`endif
          end
        end
      end
`ifdef EXCESS3_BIN_EN
      CONV: begin
        bin_d = bin_q * W'(10) + W'(conv_digit);
        if (idx_q == 3'd0) state_d = OUT;
        else               idx_d = idx_q - 3'd1;
      end
`endif
      OUT: begin
        if (out_ready) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef EXCESS3_BIN_EN
          bin_d   = '0;
`endif
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef EXCESS3_BIN_EN
      bin_q   <= '0;
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef EXCESS3_BIN_EN
      bin_q   <= bin_d;
      idx_q   <= idx_d;
`endif
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign out_bcd   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_err   = err_q;
`ifdef EXCESS3_BIN_EN
  assign out_bin   = bin_q;
`endif

endmodule

// File: tb/tb_excess3_bcd_packer.sv
// Directed bench for excess3_bcd_packer; out_bin checks follow EXCESS3_BIN_EN.
module tb_excess3_bcd_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_xs3;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bcd;
  logic [3:0]  out_cnt;
  logic        out_err;
`ifdef EXCESS3_BIN_EN
  logic [15:0] out_bin;
`endif

  int pass_count = 0;
  int total_count = 0;
  int lat;
  int len;
  int exp_bin;
  logic [3:0]  code;
  logic [3:0]  d;
  logic [15:0] exp_bcd;
  logic        exp_err;

  excess3_bcd_packer #(.NDIG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_xs3(in_xs3), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd), .out_cnt(out_cnt),
`ifdef EXCESS3_BIN_EN
    .out_bin(out_bin),
`endif
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Offers one digit after an idle gap and returns just after the accepting edge.
  task automatic applyStimulus(input logic [3:0] c, input logic last, input int idle);
    int guard = 0;
    repeat (idle) @(negedge clk);
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkOutput("in_ready timeout", in_ready, 1);
    in_valid = 1'b1;
    in_xs3   = c;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitOut(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 100);
    checkOutput("out_valid timeout", out_valid, 1);
  endtask

  task automatic takeOut();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("out_valid after handshake", out_valid, 0);
    checkOutput("in_ready after handshake", in_ready, 1);
  endtask

  function automatic int expLatency(input int cnt);
`ifdef EXCESS3_BIN_EN
    return cnt + 1;
`else
    return 1;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_xs3 = 4'h0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset out_bcd", out_bcd, 0);
    checkOutput("reset out_cnt", out_cnt, 0);
    checkOutput("reset out_err", out_err, 0);
`ifdef EXCESS3_BIN_EN
    checkOutput("reset out_bin", out_bin, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Full word 1359
    applyStimulus(4'b0100, 1'b0, 0);
    applyStimulus(4'b0110, 1'b0, 0);
    applyStimulus(4'b1000, 1'b0, 0);
    applyStimulus(4'b1100, 1'b0, 0);
    waitOut(lat);
    checkOutput("full latency", lat, expLatency(4));
    checkOutput("full bcd", out_bcd, 16'h1359);
    checkOutput("full cnt", out_cnt, 4);
    checkOutput("full err", out_err, 0);
    checkOutput("full in_ready", in_ready, 0);
`ifdef EXCESS3_BIN_EN
    checkOutput("full bin", out_bin, 16'h054F);
`endif
    takeOut();

    // Short word closed by in_last
    applyStimulus(4'b0011, 1'b0, 0);
    applyStimulus(4'b1011, 1'b1, 0);
    waitOut(lat);
    checkOutput("short latency", lat, expLatency(2));
    checkOutput("short bcd", out_bcd, 16'h0008);
    checkOutput("short cnt", out_cnt, 2);
    checkOutput("short err", out_err, 0);
`ifdef EXCESS3_BIN_EN
    checkOutput("short bin", out_bin, 16'h0008);
`endif
    takeOut();

    // Illegal codes, then a clean word clears the error
    applyStimulus(4'b1111, 1'b0, 0);
    applyStimulus(4'b0101, 1'b0, 0);
    applyStimulus(4'b0000, 1'b0, 0);
    applyStimulus(4'b0111, 1'b0, 0);
    waitOut(lat);
    checkOutput("illegal bcd", out_bcd, 16'h0204);
    checkOutput("illegal err", out_err, 1);
    checkOutput("illegal cnt", out_cnt, 4);
`ifdef EXCESS3_BIN_EN
    checkOutput("illegal bin", out_bin, 16'h00CC);
`endif
    takeOut();
    applyStimulus(4'b0011, 1'b1, 0);
    waitOut(lat);
    checkOutput("after illegal bcd", out_bcd, 16'h0000);
    checkOutput("after illegal cnt", out_cnt, 1);
    checkOutput("after illegal err", out_err, 0);
    takeOut();

    // Backpressure with a digit offered the whole time
    applyStimulus(4'hC, 1'b0, 0);
    applyStimulus(4'hB, 1'b0, 0);
    applyStimulus(4'hA, 1'b0, 0);
    applyStimulus(4'h9, 1'b0, 0);
    waitOut(lat);
    in_valid = 1'b1; in_xs3 = 4'b0100; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp out_valid", out_valid, 1);
      checkOutput("bp in_ready", in_ready, 0);
      checkOutput("bp bcd", out_bcd, 16'h9876);
      checkOutput("bp cnt", out_cnt, 4);
`ifdef EXCESS3_BIN_EN
      checkOutput("bp bin", out_bin, 16'h2694);
`endif
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checkOutput("bp handshake out_valid", out_valid, 0);
    checkOutput("bp no accept cnt", out_cnt, 0);
    applyStimulus(4'b0110, 1'b1, 0);
    waitOut(lat);
    checkOutput("after bp bcd", out_bcd, 16'h0003);
    checkOutput("after bp cnt", out_cnt, 1);
    takeOut();

    // Reset in the middle of a word
    applyStimulus(4'b0111, 1'b0, 0);
    applyStimulus(4'b1000, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset in_ready", in_ready, 1);
    checkOutput("midreset out_valid", out_valid, 0);
    checkOutput("midreset bcd", out_bcd, 0);
    checkOutput("midreset cnt", out_cnt, 0);
    checkOutput("midreset err", out_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(4'b0100, 1'b0, 0);
    waitOut(lat);
    checkOutput("post reset bcd", out_bcd, 16'h1111);
    checkOutput("post reset cnt", out_cnt, 4);
    takeOut();

    // All codes in every position, then random words, with random gaps
    for (int w = 0; w < 28; w++) begin
      len = (w < 16) ? 4 : int'($urandom_range(1, 4));
      exp_bcd = 16'h0; exp_bin = 0; exp_err = 1'b0;
      for (int p = 0; p < len; p++) begin
        code = (w < 16) ? 4'((w + p * 5) % 16) : 4'($urandom_range(0, 15));
        if (code >= 4'd3 && code <= 4'd12) d = code - 4'd3;
        else begin
          d = 4'd0;
          exp_err = 1'b1;
        end
        exp_bcd = {exp_bcd[11:0], d};
        exp_bin = exp_bin * 10 + int'(d);
        applyStimulus(code, (p == len - 1), int'($urandom_range(0, 2)));
      end
      waitOut(lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checkOutput("model bcd", out_bcd, exp_bcd);
      checkOutput("model cnt", out_cnt, len);
      checkOutput("model err", out_err, exp_err);
`ifdef EXCESS3_BIN_EN
      checkOutput("model bin", out_bin, exp_bin);
`endif
      takeOut();
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
